// File: rtl/switch_allocator_wh_pkg.sv
// Shared NoC router parameters and types for the wormhole switch allocator.
package switch_allocator_wh_pkg;

    localparam int unsigned DefPortCnt = 5;
    localparam int unsigned DefVcNum   = 4;

    typedef enum logic [2:0] {
        PortLocal = 3'd0,
        PortNorth = 3'd1,
        PortSouth = 3'd2,
        PortWest  = 3'd3,
        PortEast  = 3'd4
    } port_e;

    localparam int unsigned PortIdxW = $clog2(DefPortCnt);
    localparam int unsigned VcIdxW   = $clog2(DefVcNum);

    typedef logic [PortIdxW-1:0] port_idx_t;
    typedef logic [VcIdxW-1:0]   vc_idx_t;

    typedef struct packed {
        port_idx_t ip;
        vc_idx_t   vc;
    } lock_owner_t;

    function automatic int unsigned wrap_inc(int unsigned cur, int unsigned n);
        return (cur + 1) % n;
    endfunction

endpackage

// File: rtl/switch_allocator_wh_rr_arbiter.sv
// Round-robin arbiter: one-hot grant starting the search at an externally updated pointer.
module switch_allocator_wh_rr_arbiter #(
    parameter int unsigned N = 4,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  gnt,
    input  logic          upd_en,
    input  logic [IW-1:0] upd_val
);

    logic [IW-1:0] ptr_q;
    logic [IW-1:0] idx;
    logic          found;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (upd_en) begin
            ptr_q <= upd_val;
        end
    end

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = IW'((32'(ptr_q) + k) % N);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/switch_allocator_wh.sv
// Separable input-first switch allocator with wormhole output locks and iSLIP pointer update.
module switch_allocator_wh
    import switch_allocator_wh_pkg::*;
#(
    parameter int unsigned PORT_CNT = DefPortCnt,
    parameter int unsigned VC_NUM   = DefVcNum,
    parameter bit          LOCK_EN  = 1'b1
) (
    input  logic                                                 clk,
    input  logic                                                 rst,
    input  logic [PORT_CNT-1:0][VC_NUM-1:0]                      req_i,
    input  logic [PORT_CNT-1:0][VC_NUM-1:0][$clog2(PORT_CNT)-1:0] out_port_i,
    input  logic [PORT_CNT-1:0][VC_NUM-1:0]                      tail_i,
    input  logic [PORT_CNT-1:0][VC_NUM-1:0]                      credit_ok_i,
    output logic [PORT_CNT-1:0][VC_NUM-1:0]                      grant_o,
    output logic [PORT_CNT-1:0]                                  lock_valid_o,
    output logic [PORT_CNT-1:0][$clog2(PORT_CNT)+$clog2(VC_NUM)-1:0] lock_owner_o
);

    localparam int unsigned PW = $clog2(PORT_CNT);
    localparam int unsigned VW = $clog2(VC_NUM);

    logic [PORT_CNT-1:0][VC_NUM-1:0]   elig, s1_gnt, grant_d, grant_q;
    logic [PORT_CNT-1:0]               s1_valid, s1_tail, in_win, out_busy;
    logic [PORT_CNT-1:0][PW-1:0]       s1_port, ip_upd;
    logic [PORT_CNT-1:0][VW-1:0]       s1_vc, vc_upd;
    // Stage-2 matrices are indexed [output][input].
    logic [PORT_CNT-1:0][PORT_CNT-1:0] req2, gnt2, out_gnt;

    logic [PORT_CNT-1:0]               lock_valid_q, lock_valid_d;
    logic [PORT_CNT-1:0][PW-1:0]       lock_ip_q, lock_ip_d;
    logic [PORT_CNT-1:0][VW-1:0]       lock_vc_q, lock_vc_d;

    // Out-of-range ports match no output and so are never eligible.
    always_comb begin
        elig = '0;
        for (int i = 0; i < PORT_CNT; i++) begin
            for (int v = 0; v < VC_NUM; v++) begin
                for (int o = 0; o < PORT_CNT; o++) begin
                    if (out_port_i[i][v] == PW'(o)) begin
                        elig[i][v] = req_i[i][v] & credit_ok_i[i][v] &
                                     (!lock_valid_q[o] ||
                                      (lock_ip_q[o] == PW'(i) && lock_vc_q[o] == VW'(v)));
                    end
                end
            end
        end
    end

    for (genvar gi = 0; gi < PORT_CNT; gi++) begin : g_vc_arb
        switch_allocator_wh_rr_arbiter #(
            .N (VC_NUM)
        ) u_vc_arb (
            .clk     (clk),
            .rst     (rst),
            .req     (elig[gi]),
            .gnt     (s1_gnt[gi]),
            .upd_en  (in_win[gi]),
            .upd_val (vc_upd[gi])
        );
    end

    always_comb begin
        s1_valid = '0;
        s1_port  = '0;
        s1_vc    = '0;
        s1_tail  = '0;
        for (int i = 0; i < PORT_CNT; i++) begin
            s1_valid[i] = |s1_gnt[i];
            for (int v = 0; v < VC_NUM; v++) begin
                if (s1_gnt[i][v]) begin
                    s1_port[i] = out_port_i[i][v];
                    s1_vc[i]   = VW'(v);
                    s1_tail[i] = tail_i[i][v];
                end
            end
        end
    end

    always_comb begin
        req2 = '0;
        for (int o = 0; o < PORT_CNT; o++) begin
            for (int i = 0; i < PORT_CNT; i++) begin
                req2[o][i] = s1_valid[i] && (s1_port[i] == PW'(o));
            end
        end
    end

    for (genvar go = 0; go < PORT_CNT; go++) begin : g_ip_arb
        switch_allocator_wh_rr_arbiter #(
            .N (PORT_CNT)
        ) u_ip_arb (
            .clk     (clk),
            .rst     (rst),
            .req     (req2[go]),
            .gnt     (gnt2[go]),
            .upd_en  (out_busy[go]),
            .upd_val (ip_upd[go])
        );
    end

    // A locked output bypasses its arbiter and serves only the owning (input, vc).
    always_comb begin
        out_gnt = '0;
        for (int o = 0; o < PORT_CNT; o++) begin
            if (lock_valid_q[o]) begin
                for (int i = 0; i < PORT_CNT; i++) begin
                    if (lock_ip_q[o] == PW'(i)) begin
                        out_gnt[o][i] = req2[o][i] && (s1_vc[i] == lock_vc_q[o]);
                    end
                end
            end else begin
                out_gnt[o] = gnt2[o];
            end
        end
    end

    always_comb begin
        in_win   = '0;
        out_busy = '0;
        ip_upd   = '0;
        vc_upd   = '0;
        grant_d  = '0;
        for (int o = 0; o < PORT_CNT; o++) begin
            out_busy[o] = |out_gnt[o];
            for (int i = 0; i < PORT_CNT; i++) begin
                if (out_gnt[o][i]) begin
                    in_win[i] = 1'b1;
                    ip_upd[o] = PW'(wrap_inc(32'(i), PORT_CNT));
                end
            end
        end
        for (int i = 0; i < PORT_CNT; i++) begin
            vc_upd[i]  = VW'(wrap_inc(32'(s1_vc[i]), VC_NUM));
            grant_d[i] = in_win[i] ? s1_gnt[i] : '0;
        end
    end

    always_comb begin
        lock_valid_d = lock_valid_q;
        lock_ip_d    = lock_ip_q;
        lock_vc_d    = lock_vc_q;
        if (LOCK_EN) begin
            for (int o = 0; o < PORT_CNT; o++) begin
                for (int i = 0; i < PORT_CNT; i++) begin
                    if (out_gnt[o][i]) begin
                        lock_valid_d[o] = !s1_tail[i];
                        lock_ip_d[o]    = s1_tail[i] ? '0 : PW'(i);
                        lock_vc_d[o]    = s1_tail[i] ? '0 : s1_vc[i];
                    end
                end
            end
        end else begin
            lock_valid_d = '0;
            lock_ip_d    = '0;
            lock_vc_d    = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_q      <= '0;
            lock_valid_q <= '0;
            lock_ip_q    <= '0;
            lock_vc_q    <= '0;
        end else begin
            grant_q      <= grant_d;
            lock_valid_q <= lock_valid_d;
            lock_ip_q    <= lock_ip_d;
            lock_vc_q    <= lock_vc_d;
        end
    end

    always_comb begin
        lock_owner_o = '0;
        for (int o = 0; o < PORT_CNT; o++) begin
            lock_owner_o[o] = {lock_ip_q[o], lock_vc_q[o]};
        end
    end

    assign grant_o      = grant_q;
    assign lock_valid_o = lock_valid_q;

endmodule

// File: tb/tb_switch_allocator_wh.sv
// Directed and randomized checks of switch_allocator_wh against a behavioural model.
module tb_switch_allocator_wh;
    import switch_allocator_wh_pkg::*;

    localparam int P  = 5;
    localparam int V  = 4;
    localparam int PW = 3;
    localparam int VW = 2;

    logic clk = 1'b0;
    logic rst;
    logic [P-1:0][V-1:0]         req, tail, credit, grant;
    logic [P-1:0][V-1:0][PW-1:0] out_port;
    logic [P-1:0]                lock_valid;
    logic [P-1:0][PW+VW-1:0]     lock_owner;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: plain integers for pointers and the lock table.
    int m_vc_ptr[P];
    int m_ip_ptr[P];
    bit m_lk_v[P];
    int m_lk_i[P];
    int m_lk_vc[P];
    logic [P-1:0][V-1:0] exp_g, m_elig;

    always #5 clk = ~clk;

    switch_allocator_wh #(
        .PORT_CNT (P),
        .VC_NUM   (V),
        .LOCK_EN  (1'b1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_i        (req),
        .out_port_i   (out_port),
        .tail_i       (tail),
        .credit_ok_i  (credit),
        .grant_o      (grant),
        .lock_valid_o (lock_valid),
        .lock_owner_o (lock_owner)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < P; k++) begin
            m_vc_ptr[k] = 0;
            m_ip_ptr[k] = 0;
            m_lk_v[k]   = 1'b0;
            m_lk_i[k]   = 0;
            m_lk_vc[k]  = 0;
        end
        exp_g = '0;
    endtask

    function automatic bit m_eligible(int i, int v);
        int o;
        o = int'(out_port[i][v]);
        if (!req[i][v] || !credit[i][v] || o >= P) return 1'b0;
        if (m_lk_v[o] && !(m_lk_i[o] == i && m_lk_vc[o] == v)) return 1'b0;
        return 1'b1;
    endfunction

    // One allocation round from the current inputs; advances model state to post-edge.
    task automatic model_step();
        int sel[P];
        int win[P];
        int i, v, c;
        exp_g  = '0;
        m_elig = '0;
        for (int a = 0; a < P; a++) begin
            sel[a] = -1;
            for (int k = 0; k < V; k++) begin
                c = (m_vc_ptr[a] + k) % V;
                if (m_eligible(a, c)) begin
                    m_elig[a][c] = 1'b1;
                    if (sel[a] < 0) sel[a] = c;
                end
            end
        end
        for (int o = 0; o < P; o++) begin
            win[o] = -1;
            if (m_lk_v[o]) begin
                i = m_lk_i[o];
                if (sel[i] == m_lk_vc[o] && int'(out_port[i][sel[i]]) == o) win[o] = i;
            end else begin
                for (int k = 0; k < P; k++) begin
                    c = (m_ip_ptr[o] + k) % P;
                    if (win[o] < 0 && sel[c] >= 0 && int'(out_port[c][sel[c]]) == o) win[o] = c;
                end
            end
        end
        for (int o = 0; o < P; o++) begin
            if (win[o] >= 0) begin
                i = win[o];
                v = sel[i];
                exp_g[i][v] = 1'b1;
                m_vc_ptr[i] = (v + 1) % V;
                m_ip_ptr[o] = (i + 1) % P;
                m_lk_v[o]   = !tail[i][v];
                m_lk_i[o]   = i;
                m_lk_vc[o]  = v;
            end
        end
    endtask

    task automatic check_all(input string tag);
        logic [P-1:0] lv;
        int bad;
        lv  = '0;
        bad = 0;
        for (int o = 0; o < P; o++) begin
            lv[o] = m_lk_v[o];
            if (m_lk_v[o]) check_eq({tag, "/owner"}, 64'(lock_owner[o]), 64'(m_lk_i[o] * V + m_lk_vc[o]));
        end
        for (int i = 0; i < P; i++) if (!$onehot0(grant[i])) bad++;
        check_eq({tag, "/grant"}, 64'(grant), 64'(exp_g));
        check_eq({tag, "/lock_valid"}, 64'(lock_valid), 64'(lv));
        check_eq({tag, "/row1hot"}, 64'(bad), 64'(0));
        check_eq({tag, "/elig"}, 64'(grant & ~m_elig), 64'(0));
    endtask

    task automatic step(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic clear_inputs();
        req      = '0;
        tail     = '0;
        credit   = '1;
        out_port = '0;
    endtask

    task automatic set_req(input int i, input int v, input int p, input bit t);
        req[i][v]      = 1'b1;
        out_port[i][v] = 3'(p);
        tail[i][v]     = t;
        credit[i][v]   = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        check_eq("rst_async_grant", 64'(grant), 64'(0));
        check_eq("rst_async_lock", 64'(lock_valid), 64'(0));
        @(posedge clk);
        #1;
        check_eq("rst_held_grant", 64'(grant), 64'(0));
        #2;
        rst = 1'b0;
    endtask

    task automatic randomize_inputs();
        for (int i = 0; i < P; i++) begin
            for (int v = 0; v < V; v++) begin
                req[i][v]    = ($urandom_range(0, 9) < 6);
                credit[i][v] = ($urandom_range(0, 9) < 8);
                tail[i][v]   = ($urandom_range(0, 9) < 4);
                out_port[i][v] = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7))
                                                             : 3'($urandom_range(0, 4));
            end
        end
    endtask

    initial begin
        // Reset with every request asserted: nothing may be granted.
        rst      = 1'b1;
        req      = '1;
        credit   = '1;
        tail     = '1;
        out_port = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_eq("t1_rst_grant", 64'(grant), 64'(0));
        check_eq("t1_rst_lock", 64'(lock_valid), 64'(0));
        clear_inputs();
        rst = 1'b0;
        step("t1_idle");
        check_eq("t1_idle_grant", 64'(grant), 64'(0));
        set_req(1, 2, PortEast, 1'b1);
        step("t1");
        check_eq("t1_latency", 64'(grant), 64'h40);

        // Three inputs contend for NORTH; grants rotate 0,1,2,0.
        clear_inputs();
        for (int i = 0; i < 3; i++) set_req(i, 0, PortNorth, 1'b1);
        step("t2a"); check_eq("t2_rot0", 64'(grant), 64'h1);
        step("t2b"); check_eq("t2_rot1", 64'(grant), 64'h10);
        step("t2c"); check_eq("t2_rot2", 64'(grant), 64'h100);
        step("t2d"); check_eq("t2_rot3", 64'(grant), 64'h1);

        // Input 3 loses SOUTH with VC1 and must retry VC1 next cycle.
        clear_inputs();
        set_req(0, 0, PortSouth, 1'b1);
        set_req(3, 1, PortSouth, 1'b1);
        set_req(3, 2, PortWest, 1'b1);
        step("t3a"); check_eq("t3_in0_wins", 64'(grant), 64'h1);
        req[0][0] = 1'b0;
        step("t3b"); check_eq("t3_vc_hold", 64'(grant), 64'h2000);

        // Wormhole lock on WEST by input 2 VC3, plus credit gating of the owner.
        clear_inputs();
        set_req(2, 3, PortWest, 1'b0);
        step("t4_head");
        check_eq("t4_head_grant", 64'(grant), 64'h800);
        check_eq("t4_lock_set", 64'(lock_valid), 64'h8);
        check_eq("t4_owner", 64'(lock_owner[3]), 64'd11);
        clear_inputs();
        set_req(4, 0, PortWest, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step("t4_block");
            check_eq("t4_blocked", 64'(grant), 64'(0));
        end
        set_req(2, 3, PortWest, 1'b0);
        credit[2][3] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            step("t5_nocred");
            check_eq("t5_no_grant", 64'(grant), 64'(0));
            check_eq("t5_lock_kept", 64'(lock_valid), 64'h8);
        end
        credit[2][3] = 1'b1;
        step("t5_body");
        check_eq("t5_owner_grant", 64'(grant), 64'h800);
        tail[2][3] = 1'b1;
        step("t4_tail");
        check_eq("t4_tail_grant", 64'(grant), 64'h800);
        check_eq("t4_lock_clear", 64'(lock_valid), 64'(0));
        req[2][3] = 1'b0;
        step("t4_next");
        check_eq("t4_in4_grant", 64'(grant), 64'h10000);

        // Randomized regression with reset pulses landing mid-traffic.
        for (int c = 0; c < 2000; c++) begin
            if (c == 600 || c == 1300) do_reset();
            randomize_inputs();
            step("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
